timer0_counter: RTL
===================

# timer0_counter

Timer/Counter 0 count engine for the 8051 core: owns the TL0/TH0 count registers, advances them per TMOD mode 0–3, and raises TF0 (and TF1 in mode 3) on overflow. Sits downstream of the SFR write decode. It consumes the CPU byte writes that the plain TL0/TH0 holding registers take today, and drives the values read back on the SFR bus plus the flags into TCON and the interrupt controller.

## Interface
- No parameters.
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_tick  in  1  machine-cycle enable, one i_clk cycle wide, once per 12 clocks
- i_tmod  in  4  TMOD[3:0]: {GATE, C/T, M1, M0} for timer 0
- i_tr0  in  1  TCON.TR0 run bit
- i_tr1  in  1  TCON.TR1; gates TH0 in mode 3 only
- i_int0_pin  in  1  INT0 pin level, already synchronized
- i_t0_pin  in  1  T0 external count pin, already synchronized
- i_byte  in  8  CPU write data
- i_wr_tl0  in  1  CPU write strobe for TL0
- i_wr_th0  in  1  CPU write strobe for TH0
- i_tf0_wr  in  1  software write of TCON.TF0
- i_tf0_val  in  1  value for i_tf0_wr
- i_tf0_ack  in  1  interrupt-vector acknowledge, clears TF0
- o_tl0  out  8  TL0 value
- o_th0  out  8  TH0 value
- o_tf0  out  1  TF0 flag
- o_ovf0  out  1  one-cycle pulse on timer-0 overflow
- o_tf1_set  out  1  one-cycle pulse on TH0 overflow in mode 3; TCON sets TF1 from it

## Operation
- Reset values: o_tl0=8'h00, o_th0=8'h00, o_tf0=0, o_ovf0=0, o_tf1_set=0. The T0 pin sample register resets to 1.
- Run enable: run0 = TR0 & (~GATE | i_int0_pin).
- Count event (cnt0) is evaluated only in i_tick cycles:
  - C/T=0: cnt0 = run0.
  - C/T=1: cnt0 = run0 & falling edge of T0. A falling edge means the previous i_tick sample is 1 and the current one is 0.
  - The T0 sample register updates on every i_tick regardless of run0.
- Mode 0 (13-bit):
  - Counter is {TH0, TL0[4:0]}; TL0[7:5] is held.
  - At 13'h1FFF, a count wraps both fields to 0 and sets the overflow.
- Mode 1 (16-bit): {TH0, TL0} increments; FFFF wraps to 0000 with overflow.
- Mode 2 (8-bit auto-reload): TL0 increments. On FF, TL0 is loaded from TH0 and the overflow sets. TH0 is unchanged.
- Mode 3 (split):
  - TL0 is an 8-bit counter using GATE, C/T, TR0 and TF0; FF wraps to 00 with overflow0.
  - TH0 is an 8-bit timer that always counts machine ticks (ignores C/T and GATE), enabled by i_tr1.
  - TH0 FF→00 pulses o_tf1_set and does not touch TF0.
- CPU writes:
  - i_wr_tl0 loads TL0 with i_byte; i_wr_th0 loads TH0 with i_byte.
  - Any TL0/TH0 write in the same cycle as cnt0 suppresses that count event entirely: no increment, no carry, no overflow.
  - In mode 3, i_wr_th0 suppresses only the TH0 tick count.
- TF0 update, priority high to low:
  1. Overflow sets TF0 to 1.
  2. i_tf0_wr loads i_tf0_val.
  3. i_tf0_ack clears TF0.
- Mode change mid-count: the new mode applies from the next i_tick. Registers are not cleared.

## Timing
- All outputs are registered. o_tl0/o_th0 show the incremented value on the clock edge that ends the i_tick cycle.
- o_tf0 rises and o_ovf0 pulses on the same edge as the wrap. o_ovf0 and o_tf1_set are high for exactly one i_clk cycle.
- A CPU write is visible on o_tl0/o_th0 one cycle after its strobe.
- External count latency: a falling T0 edge between ticks n-1 and n counts at tick n. T0 must stay in each state for at least one tick to be seen, so the maximum count rate is one per two ticks.
- With i_tick low, nothing changes except CPU writes and TF0 write/ack.
- Reset mid-count: the next cycle shows reset values, and the first post-reset tick cannot produce a T0 edge.

## Test plan
- Mode 1, TR0=1, TL0=FE, TH0=FF, 3 ticks → FF/FF, then 00/00 with o_ovf0 pulse and TF0=1, then 01/00.
- Mode 2, TH0=F0, TL0=FF, 1 tick → TL0=F0, TH0=F0, TF0=1. i_tf0_ack then clears TF0 the next cycle.
- Mode 0, TL0=FF, TH0=FF (13-bit=1FFF), 1 tick → TL0=E0, TH0=00, TF0=1.
- Counter mode (C/T=1), T0 sampled 1,0,0,1,0 across 5 ticks → TL0 increments by exactly 2. GATE=1 with i_int0_pin=0 → no increments despite edges.
- Mode 3, TR0=0, TR1=1, TH0=FF, 1 tick → TH0=00, o_tf1_set pulse, TF0 unchanged, TL0 unchanged.
- i_wr_tl0 with i_byte=55 in the same cycle as a tick at TL0=FF (mode 1), plus an overflow in a cycle with i_tf0_wr=1, i_tf0_val=0 → TL0=55, TH0 unchanged, no overflow. Then, on the separate overflow, TF0=1 (set wins).

Source files
------------

// File: rtl/timer0_counter.sv
// 8051 Timer/Counter 0 count engine: TL0/TH0 advance per TMOD modes 0-3,
// TF0 flag handling, and the mode-3 TH0 overflow pulse that feeds TF1.
module timer0_counter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic [3:0] i_tmod,
  input  logic       i_tr0,
  input  logic       i_tr1,
  input  logic       i_int0_pin,
  input  logic       i_t0_pin,
  input  logic [7:0] i_byte,
  input  logic       i_wr_tl0,
  input  logic       i_wr_th0,
  input  logic       i_tf0_wr,
  input  logic       i_tf0_val,
  input  logic       i_tf0_ack,
  output logic [7:0] o_tl0,
  output logic [7:0] o_th0,
  output logic       o_tf0,
  output logic       o_ovf0,
  output logic       o_tf1_set
);

  localparam int unsigned W = 8;

  logic [W-1:0] tl0_q, tl0_d;
  logic [W-1:0] th0_q, th0_d;
  logic         tf0_q, tf0_d;
  logic         ovf0_q, ovf0_d;
  logic         tf1_set_q, tf1_set_d;
  logic         t0_smp_q, t0_smp_d;
  logic         t0_vld_q, t0_vld_d;

  logic         gate, ct, m3, run0, t0_fall, cnt0, tl_cnt, th_cnt;
  logic [1:0]   mode;
  logic [13:0]  cnt13;
  logic [16:0]  cnt16;
  logic [W:0]   tl_inc, th_inc;

  // Count qualification; t0_vld_q blocks a spurious edge on the first tick after reset
  always_comb begin
    gate    = i_tmod[3];
    ct      = i_tmod[2];
    mode    = i_tmod[1:0];
    m3      = (mode == 2'd3);
    run0    = i_tr0 & (~gate | i_int0_pin);
    t0_fall = t0_vld_q & t0_smp_q & ~i_t0_pin;
    cnt0    = i_tick & run0 & (~ct | t0_fall);
    tl_cnt  = cnt0 & ~(i_wr_tl0 | (~m3 & i_wr_th0));
    th_cnt  = m3 & i_tick & i_tr1 & ~i_wr_th0;
    cnt13   = {1'b0, th0_q, tl0_q[4:0]} + 14'd1;
    cnt16   = {1'b0, th0_q, tl0_q} + 17'd1;
    tl_inc  = (W+1)'(tl0_q) + (W+1)'(1);
    th_inc  = (W+1)'(th0_q) + (W+1)'(1);
  end

  // Next-state for count registers and flags
  always_comb begin
    tl0_d     = tl0_q;
    th0_d     = th0_q;
    tf0_d     = tf0_q;
    ovf0_d    = 1'b0;
    tf1_set_d = 1'b0;
    t0_smp_d  = t0_smp_q;
    t0_vld_d  = t0_vld_q;

    if (i_tick) begin
      t0_smp_d = i_t0_pin;
      t0_vld_d = 1'b1;
    end

    if (i_wr_tl0) tl0_d = i_byte;
    if (i_wr_th0) th0_d = i_byte;

    if (tl_cnt) begin
      unique case (mode)
        2'd0: begin
          th0_d      = cnt13[12:5];
          tl0_d[4:0] = cnt13[4:0];
          ovf0_d     = cnt13[13];
        end
        2'd1: begin
          th0_d  = cnt16[15:8];
          tl0_d  = cnt16[7:0];
          ovf0_d = cnt16[16];
        end
        2'd2: begin
          if (tl0_q == 8'hFF) begin
            tl0_d  = th0_q;
            ovf0_d = 1'b1;
          end else begin
            tl0_d = tl_inc[W-1:0];
          end
        end
        default: begin
          tl0_d  = tl_inc[W-1:0];
          ovf0_d = tl_inc[W];
        end
      endcase
    end

    if (th_cnt) begin
      th0_d     = th_inc[W-1:0];
      tf1_set_d = th_inc[W];
    end

    if (ovf0_d)         tf0_d = 1'b1;
    else if (i_tf0_wr)  tf0_d = i_tf0_val;
    else if (i_tf0_ack) tf0_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tl0_q     <= '0;
      th0_q     <= '0;
      tf0_q     <= 1'b0;
      ovf0_q    <= 1'b0;
      tf1_set_q <= 1'b0;
      t0_smp_q  <= 1'b1;
      t0_vld_q  <= 1'b0;
    end else begin
      tl0_q     <= tl0_d;
      th0_q     <= th0_d;
      tf0_q     <= tf0_d;
      ovf0_q    <= ovf0_d;
      tf1_set_q <= tf1_set_d;
      t0_smp_q  <= t0_smp_d;
      t0_vld_q  <= t0_vld_d;
    end
  end

  assign o_tl0     = tl0_q;
  assign o_th0     = th0_q;
  assign o_tf0     = tf0_q;
  assign o_ovf0    = ovf0_q;
  assign o_tf1_set = tf1_set_q;

endmodule
